bcd_countdown_timer: RTL and testbench

BCD_COUNTDOWN_TIMER -- requirements
Module: bcd_countdown_timer

---
 rtl/timer_pkg.sv | 21 ++
 rtl/bcd_digit_dec.sv | 30 +++
 rtl/bcd_countdown_timer.sv | 97 +++++++++
 tb/tb_bcd_countdown_timer.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared types and constants for the BCD countdown timer.
package timer_pkg;

  localparam int unsigned DIGIT_W = 4;

  localparam logic [DIGIT_W-1:0] BCD_MAX  = 4'd9;
  localparam logic [DIGIT_W-1:0] BCD_ZERO = 4'd0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Clamp a raw 4-bit value to a legal BCD digit.
  function automatic logic [DIGIT_W-1:0] sat_bcd(input logic [DIGIT_W-1:0] v);
    return (v > BCD_MAX) ? BCD_MAX : v;
  endfunction

endpackage

// File: rtl/bcd_digit_dec.sv
// Single BCD digit: saturating load, decrement with wrap 0->9, borrow-out.
module bcd_digit_dec
  import timer_pkg::*;
#(
  parameter logic [DIGIT_W-1:0] PRESET = BCD_ZERO
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [DIGIT_W-1:0] load_val,
  input  logic               dec_en,
  output logic [DIGIT_W-1:0] digit,
  output logic               borrow_c
);

  // Digit register; load beats decrement.
  always_ff @(posedge clk) begin
    if (reset) begin
      digit <= PRESET;
    end else if (load) begin
      digit <= sat_bcd(load_val);
    end else if (dec_en) begin
      digit <= (digit == BCD_ZERO) ? BCD_MAX : digit - DIGIT_W'(1);
    end
  end

  // Borrow into the next digit when decrementing through zero.
  assign borrow_c = dec_en && (digit == BCD_ZERO);

endmodule

// File: rtl/bcd_countdown_timer.sv
// Two-digit BCD countdown timer with run/pause/done control.
module bcd_countdown_timer
  import timer_pkg::*;
#(
  parameter logic [3:0] PRESET_TENS = 4'd5,
  parameter logic [3:0] PRESET_ONES = 4'd9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       start_pause,
  input  logic       load,
  input  logic [3:0] load_tens,
  input  logic [3:0] load_ones,
  output logic [3:0] bcd_tens,
  output logic [3:0] bcd_ones,
  output logic       running,
  output logic       done
);

  state_t state, state_nx;
  logic   dec;
  logic   ones_borrow_c;
  logic   tens_borrow_c;
  logic   value_nonzero;
  logic   value_is_one;

  assign value_nonzero = (bcd_tens != BCD_ZERO) || (bcd_ones != BCD_ZERO);
  assign value_is_one  = (bcd_tens == BCD_ZERO) && (bcd_ones == 4'd1);

  // State register plus registered status flags that track the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      running <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nx;
      running <= (state_nx == RUN);
      done    <= (state_nx == DONE);
    end
  end

  // Next-state and decrement decision; load has top priority, pause beats tick.
  always_comb begin
    state_nx = state;
    dec      = 1'b0;
    if (load) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start_pause) state_nx = value_nonzero ? RUN : DONE;
        end
        RUN: begin
          if (start_pause) begin
            state_nx = PAUSE;
          end else if (tick && value_nonzero) begin
            dec = 1'b1;
            if (value_is_one) state_nx = DONE;
          end
        end
        PAUSE: begin
          if (start_pause) state_nx = RUN;
        end
        default: state_nx = DONE;
      endcase
    end
  end

  // Ones digit decrements on the qualified tick.
  bcd_digit_dec #(.PRESET(PRESET_ONES)) u_ones (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_val (load_ones),
    .dec_en   (dec),
    .digit    (bcd_ones),
    .borrow_c (ones_borrow_c)
  );

  // Tens digit decrements only on a ones borrow.
  bcd_digit_dec #(.PRESET(PRESET_TENS)) u_tens (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_val (load_tens),
    .dec_en   (ones_borrow_c),
    .digit    (bcd_tens),
    .borrow_c (tens_borrow_c)
  );

  // Tens never borrows in practice since decrement is gated on a nonzero value.
  logic unused_tens_borrow;
  assign unused_tens_borrow = tens_borrow_c;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Scoreboard bench for bcd_countdown_timer against an integer-valued reference model.
module tb_bcd_countdown_timer;

  logic       clk;
  logic       reset;
  logic       tick;
  logic       start_pause;
  logic       load;
  logic [3:0] load_tens;
  logic [3:0] load_ones;
  logic [3:0] bcd_tens;
  logic [3:0] bcd_ones;
  logic       running;
  logic       done;

  typedef struct {
    logic [3:0] tens;
    logic [3:0] ones;
    logic       run;
    logic       dn;
    string      tag;
  } exp_t;

  exp_t exp_q[$];

  int checks = 0;
  int passed = 0;

  // Reference model: value as plain integer, mode 0 idle / 1 run / 2 pause / 3 done.
  int m_val  = 59;
  int m_mode = 0;

  bcd_countdown_timer dut (
    .clk         (clk),
    .reset       (reset),
    .tick        (tick),
    .start_pause (start_pause),
    .load        (load),
    .load_tens   (load_tens),
    .load_ones   (load_ones),
    .bcd_tens    (bcd_tens),
    .bcd_ones    (bcd_ones),
    .running     (running),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int clamp9(input int d);
    return (d > 9) ? 9 : d;
  endfunction

  // Drive one cycle of inputs, advance the model, queue the expected outcome.
  task automatic step(input logic r, input logic t, input logic sp, input logic ld,
                      input int lt, input int lo, input string tag);
    exp_t e;
    @(negedge clk);
    reset       = r;
    tick        = t;
    start_pause = sp;
    load        = ld;
    load_tens   = 4'(lt);
    load_ones   = 4'(lo);
    if (r) begin
      m_val  = 59;
      m_mode = 0;
    end else if (ld) begin
      m_val  = clamp9(lt) * 10 + clamp9(lo);
      m_mode = 0;
    end else begin
      case (m_mode)
        0: if (sp) m_mode = (m_val != 0) ? 1 : 3;
        1: begin
          if (sp) m_mode = 2;
          else if (t) begin
            m_val = m_val - 1;
            if (m_val == 0) m_mode = 3;
          end
        end
        2: if (sp) m_mode = 1;
        default: ;
      endcase
    end
    e.tens = 4'(m_val / 10);
    e.ones = 4'(m_val % 10);
    e.run  = (m_mode == 1);
    e.dn   = (m_mode == 3);
    e.tag  = tag;
    exp_q.push_back(e);
  endtask

  task automatic idle_cycle(input string tag);
    step(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, tag);
  endtask

  task automatic ticks(input int n, input string tag);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 0, 0, tag);
  endtask

  task automatic do_load(input int lt, input int lo, input string tag);
    step(1'b0, 1'b0, 1'b0, 1'b1, lt, lo, tag);
  endtask

  task automatic press(input string tag);
    step(1'b0, 1'b0, 1'b1, 1'b0, 0, 0, tag);
  endtask

  // Monitor: after each rising edge compare DUT outputs with the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (bcd_tens === e.tens && bcd_ones === e.ones &&
            running === e.run && done === e.dn) begin
          passed++;
        end else begin
          $display("FAIL %s: got %0d%0d run=%0b done=%0b, want %0d%0d run=%0b done=%0b",
                   e.tag, bcd_tens, bcd_ones, running, done,
                   e.tens, e.ones, e.run, e.dn);
        end
      end
    end
  end

  initial begin
    int wait_cycles;
    reset = 1'b0; tick = 1'b0; start_pause = 1'b0; load = 1'b0;
    load_tens = 4'd0; load_ones = 4'd0;

    // Reset, run, three ticks: 59 -> 56.
    step(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, "reset");
    press("start");
    ticks(3, "count59");

    // Load 20, count down to 00, extra ticks hold.
    do_load(2, 0, "load20");
    press("start20");
    ticks(1, "tick19");
    ticks(19, "to00");
    ticks(3, "hold00");
    press("done_ignore_sp");

    // Pause with simultaneous tick at 45, ticks ignored, resume.
    do_load(4, 6, "load46");
    press("start46");
    ticks(1, "tick45");
    step(1'b0, 1'b1, 1'b1, 1'b0, 0, 0, "pause_tick");
    ticks(5, "paused");
    step(1'b0, 1'b1, 1'b1, 1'b0, 0, 0, "resume_tick");
    ticks(1, "tick44");

    // Saturating load, zero load then start goes straight to done.
    do_load(12, 15, "load_sat");
    idle_cycle("idle99");
    do_load(0, 0, "load00");
    press("start00");
    ticks(2, "done_hold");

    // Borrow at 30 and terminal count at 01.
    do_load(3, 1, "load31");
    press("start31");
    ticks(2, "borrow");
    do_load(0, 2, "load02");
    press("start02");
    ticks(2, "terminal");
    idle_cycle("done_after");

    // Reset mid-count with tick, then load with reset.
    do_load(3, 4, "load34");
    press("start34");
    ticks(1, "tick33");
    step(1'b1, 1'b1, 1'b0, 1'b0, 0, 0, "reset_tick");
    step(1'b1, 1'b0, 1'b1, 1'b1, 1, 2, "reset_load");
    step(1'b0, 1'b0, 1'b1, 1'b1, 0, 7, "load_vs_sp");

    // Randomized traffic, including held pulses and out-of-range loads.
    for (int i = 0; i < 600; i++) begin
      logic r, t, sp, ld;
      r  = ($urandom_range(0, 99) < 2);
      ld = ($urandom_range(0, 99) < 5);
      sp = ($urandom_range(0, 99) < 10);
      t  = ($urandom_range(0, 99) < 55);
      step(r, t, sp, ld, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), "random");
    end

    // Drain the scoreboard with a bounded wait.
    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 10) begin
      @(negedge clk);
      wait_cycles++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
